// File: rtl/demux2_lane_packer.sv
// demux2_lane_packer: reassembles the two serial lanes of a 1:2 bit demux
// into WIDTH-bit words. Each lane has one hold register. Completed words
// leave on a single valid/ready port with round-robin arbitration.

// Per-lane assembler: LSB-first shift-in, bit counter, one-word hold, sticky overrun.
module demux2_lane_asm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,        // capture din this edge
  input  logic             din,
  input  logic             take,       // hold moves to the output stage this edge
  output logic             hold_vld,
  output logic [WIDTH-1:0] hold_data,
  output logic             ovr
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic             last;

  // The top bit never needs storage; it is taken straight from din on the completing edge.
  assign last = (cnt == CW'(WIDTH-1));

  // Shift-in, word completion, hold fill/drain and overrun flagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      ovr       <= 1'b0;
    end else begin
      if (take) hold_vld <= 1'b0;
      if (cap) begin
        if (last) begin
          cnt <= '0;
          // A hold leaving on this edge frees room for the new word.
          if (!hold_vld || take) begin
            hold_vld  <= 1'b1;
            hold_data <= {din, sr};
          end else begin
            ovr <= 1'b1;
          end
        end else begin
          sr[cnt] <= din;
          cnt     <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module demux2_lane_packer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             S,
  input  logic             Y1,
  input  logic             Y2,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lane,
  output logic [1:0]       overrun
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            cap, din, take, hold_vld, ovr;
  logic [NUM_LANES-1:0][WIDTH-1:0] hold_data;
  logic                            pref;   // lane preferred when both holds are full
  logic                            load_en, any_full, grant;

  // S steers the bit exactly like the upstream demux: 0 -> lane 1, 1 -> lane 2.
  assign cap = {bit_valid & S, bit_valid & ~S};
  assign din = {Y2, Y1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux2_lane_asm #(.WIDTH(WIDTH)) u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap       (cap[i]),
      .din       (din[i]),
      .take      (take[i]),
      .hold_vld  (hold_vld[i]),
      .hold_data (hold_data[i]),
      .ovr       (ovr[i])
    );
  end

  assign overrun = ovr;

  // Arbitration: a lone full hold wins outright; round-robin only when both are full.
  always_comb begin
    load_en  = !out_valid || out_ready;
    any_full = |hold_vld;
    grant    = (&hold_vld) ? pref : hold_vld[1];
    take     = {grant, ~grant} & {NUM_LANES{load_en & any_full}};
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= 1'b0;
      pref      <= 1'b0;
    end else if (load_en) begin
      out_valid <= any_full;
      if (any_full) begin
        out_data <= hold_data[grant];
        out_lane <= grant;
        if (&hold_vld) pref <= ~pref;
      end
    end
  end
endmodule

// File: tb/tb_demux2_lane_packer.sv
// Randomized and directed bench for demux2_lane_packer against a word-level reference model.
module tb_demux2_lane_packer;
  localparam int W = 8;

  logic         clk = 0, rst_n = 0;
  logic         bit_valid = 0, S = 0, Y1 = 0, Y2 = 0, out_ready = 0;
  logic         out_valid, out_lane;
  logic [W-1:0] out_data;
  logic [1:0]   overrun;

  int checks = 0, failures = 0;

  // Reference model state
  int           m_cnt [2];
  logic [W-1:0] m_acc [2];
  logic [W-1:0] m_hd  [2];
  bit           m_hv  [2];
  bit           m_ov, m_ol, m_ptr;
  logic [W-1:0] m_od;
  logic [1:0]   m_ovr;

  logic [8:0]   obs_q[$];   // accepted words as {lane, data}

  demux2_lane_packer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .S(S), .Y1(Y1), .Y2(Y2),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_lane(out_lane), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_cnt[l] = 0; m_acc[l] = '0; m_hd[l] = '0; m_hv[l] = 0;
    end
    m_ov = 0; m_ol = 0; m_ptr = 0; m_od = '0; m_ovr = 2'b00;
  endtask

  // One clock edge of the behaviour, from the inputs currently applied.
  task automatic model_edge();
    int  g;
    bit  ln, b;
    g = -1;
    if (!m_ov || out_ready) begin
      if (m_hv[0] && m_hv[1]) begin g = m_ptr; m_ptr = ~m_ptr; end
      else if (m_hv[0]) g = 0;
      else if (m_hv[1]) g = 1;
      if (g >= 0) begin
        m_ov = 1; m_od = m_hd[g]; m_ol = (g == 1); m_hv[g] = 0;
      end else m_ov = 0;
    end
    if (bit_valid) begin
      ln = S;
      b  = S ? Y2 : Y1;
      m_acc[ln] = m_acc[ln] | (W'(b) << m_cnt[ln]);
      m_cnt[ln]++;
      if (m_cnt[ln] == W) begin
        if (!m_hv[ln]) begin m_hv[ln] = 1; m_hd[ln] = m_acc[ln]; end
        else m_ovr[ln] = 1'b1;
        m_cnt[ln] = 0; m_acc[ln] = '0;
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_lane", out_lane, m_ol);
    end
    chk("overrun", overrun, m_ovr);
  endtask

  // Called at a negedge: apply inputs, cross one rising edge, check at the next negedge.
  task automatic step(input logic bv, input logic s, input logic y1, input logic y2, input logic rdy);
    bit_valid = bv; S = s; Y1 = y1; Y2 = y2; out_ready = rdy;
    if (out_valid && rdy) obs_q.push_back({out_lane, out_data});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic send_word(input bit lane, input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) begin
      bit r;
      r = 1'($urandom_range(0, 1));
      if (lane) step(1'b1, 1'b1, r, w[i], rdy);
      else      step(1'b1, 1'b0, w[i], r, rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), rdy);
  endtask

  task automatic chk_obs(input string tag, input logic [8:0] exp);
    logic [31:0] got;
    got = (obs_q.size() > 0) ? {23'd0, obs_q.pop_front()} : 32'hDEAD;
    chk(tag, got, {23'd0, exp});
  endtask

  // Asynchronous reset pulse placed between clock edges; leaves time at negedge+3.
  task automatic pulse_reset();
    #1 rst_n = 0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_lane", out_lane, 1'b0);
    chk("rst_ovr", overrun, 2'b00);
    model_reset();
    obs_q.delete();
    #1 rst_n = 1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, 8'h00);
    chk("reset_lane", out_lane, 1'b0);
    chk("reset_ovr", overrun, 2'b00);
    rst_n = 1;
    @(negedge clk);

    // Lane-1 word A5, visible one cycle after the last bit, for one cycle.
    send_word(1'b0, 8'hA5, 1'b1);
    chk("a5_not_yet", out_valid, 1'b0);
    idle(1, 1'b1);
    chk("a5_valid", out_valid, 1'b1);
    chk("a5_data", out_data, 8'hA5);
    chk("a5_lane", out_lane, 1'b0);
    idle(1, 1'b1);
    chk("a5_one_cycle", out_valid, 1'b0);
    obs_q.delete();

    // Interleaved lanes: 3C on lane 1, C3 on lane 2.
    begin
      logic [W-1:0] a, b;
      a = 8'h3C; b = 8'hC3;
      for (int i = 0; i < W; i++) begin
        step(1'b1, 1'b0, a[i], 1'($urandom), 1'b1);
        step(1'b1, 1'b1, 1'($urandom), b[i], 1'b1);
      end
    end
    idle(3, 1'b1);
    chk_obs("ilv_first", {1'b0, 8'h3C});
    chk_obs("ilv_second", {1'b1, 8'hC3});

    // Round robin with both holds full, twice.
    send_word(1'b0, 8'h55, 1'b0);
    send_word(1'b0, 8'h11, 1'b0);
    send_word(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 8'h55);
      chk("bp_lane", out_lane, 1'b0);
    end
    idle(4, 1'b1);
    chk_obs("rr1_a", {1'b0, 8'h55});
    chk_obs("rr1_b", {1'b0, 8'h11});
    chk_obs("rr1_c", {1'b1, 8'h22});
    send_word(1'b1, 8'h66, 1'b0);
    send_word(1'b0, 8'h11, 1'b0);
    send_word(1'b1, 8'h22, 1'b0);
    idle(4, 1'b1);
    chk_obs("rr2_a", {1'b1, 8'h66});
    chk_obs("rr2_b", {1'b1, 8'h22});
    chk_obs("rr2_c", {1'b0, 8'h11});

    // Overrun on lane 2.
    pulse_reset();
    send_word(1'b1, 8'h01, 1'b0);
    send_word(1'b1, 8'h02, 1'b0);
    send_word(1'b1, 8'h03, 1'b0);
    chk("ovr_set", overrun, 2'b10);
    idle(4, 1'b1);
    chk_obs("ovr_w1", {1'b1, 8'h01});
    chk_obs("ovr_w2", {1'b1, 8'h02});
    chk("ovr_no_w3", obs_q.size(), 0);
    chk("ovr_sticky", overrun, 2'b10);

    // Reset mid-word discards the partial bits.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_reset();
    send_word(1'b0, 8'hFF, 1'b1);
    idle(2, 1'b1);
    chk_obs("rst_mid_word", {1'b0, 8'hFF});
    chk("rst_mid_only", obs_q.size(), 0);

    // Random traffic against the model.
    pulse_reset();
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 4) < 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux2_lane_packer.md
Name: demux2_lane_packer

Overview:
- Downstream consumer of the 1:2 bit demultiplexer (select S, outputs Y1/Y2).
- Collects the serial bits routed to each lane into WIDTH-bit words, one assembler per lane.
- Buffers one completed word per lane.
- Presents completed words on a single valid/ready output with round-robin lane arbitration.

Parameters:
- WIDTH, 8, bits per assembled word (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- bit_valid  input  1  a demux output bit is present this cycle.
- S  input  1  lane select, same signal that drives the demux; 0 = lane 1, 1 = lane 2.
- Y1  input  1  demux lane-1 output.
- Y2  input  1  demux lane-2 output.
- out_ready  input  1  downstream accepts a word.
- out_valid  output  1  out_data/out_lane valid.
- out_data  output  WIDTH  assembled word.
- out_lane  output  1  source lane of out_data; 0 = lane 1, 1 = lane 2.
- overrun  output  2  sticky per-lane word-loss flags; bit0 = lane 1, bit1 = lane 2.

Behaviour:
- Clock and reset: single clock domain (clk). rst_n is asynchronous, active-low.
- Reset values:
  - out_valid=0, out_data=0, out_lane=0, overrun=2'b00.
  - Both shift registers and bit counters = 0.
  - Both hold registers empty.
  - Round-robin pointer set so lane 1 is preferred.
- Reset mid-word: discards all partial words, held words and the output word. No output follows until a fresh WIDTH bits are collected.
- Bit capture:
  - On a clk edge with bit_valid=1, exactly one lane captures a bit: lane 1 takes Y1 when S=0, lane 2 takes Y2 when S=1.
  - The non-selected lane's input is ignored and its counter is unchanged.
  - Bit order is LSB-first: the k-th captured bit (k=0..WIDTH-1) lands in word bit k.
  - Counter runs 0..WIDTH-1.
  - On the edge capturing bit WIDTH-1, the completed word (including that bit) moves to the lane hold register and the counter wraps to 0. Capture continues with no gap cycle.
- Hold register, one entry per lane:
  - If the lane completes a word while its hold is full and that hold is not moving to the output stage on the same edge, the new word is dropped, the old word is kept, and overrun[lane] is set.
  - If the hold moves to output on the same edge a word completes, the new word fills the hold and no overrun occurs.
  - overrun bits clear only on reset.
- Output stage, one register:
  - Loads when (out_valid=0) or (out_valid=1 and out_ready=1).
  - If exactly one hold is full, that hold loads.
  - If both are full, the lane not granted last loads and the pointer flips to the other lane.
  - out_valid stays 1 and out_data/out_lane stay stable while out_ready=0.
- Latency:
  - Word completes at edge N (hold full).
  - out_valid=1 after edge N+1 if the output stage is free; minimum 1 cycle from last bit to out_valid.
- Throughput: one word per cycle sustained when out_ready=1. Two back-to-back full holds drain on consecutive cycles.
- bit_valid=0: no state change in the assemblers. The output/handshake logic still operates.

Test Plan:
- Reset then lane-1 word:
  - Stimulus: S=0, bit_valid=1 for 8 cycles, Y1 sequence 1,0,1,0,0,1,0,1, out_ready=1.
  - Required: out_valid=1 for one cycle, 1 cycle after the 8th bit, out_data=8'hA5, out_lane=0, overrun=00.
- Interleaved lanes:
  - Stimulus: alternate S=0/1 each cycle, Y1 bits give 8'h3C, Y2 bits give 8'hC3.
  - Required: the lane-1 word completes first, so the output is 8'h3C/lane0 then 8'hC3/lane1. No corruption between lanes.
- Simultaneous holds, round-robin:
  - Stimulus: out_ready=0 until both holds are full (lane1=8'h11, lane2=8'h22), then out_ready=1.
  - Required: after the initial grant to lane1, the order is 11/lane0 then 22/lane1.
  - Repeat the fill with the output stalled and check the next grant alternates.
- Backpressure stability:
  - Stimulus: out_ready=0 for 10 cycles with out_valid=1.
  - Required: out_data, out_lane and out_valid are unchanged every cycle, and the word is accepted on the first out_ready=1 edge.
- Overrun:
  - Stimulus: out_ready=0, send 3 full lane-2 words 8'h01, 8'h02, 8'h03.
  - Required: output holds 01, hold keeps 02, 03 is dropped, overrun=2'b10.
  - Then out_ready=1: words 01 then 02 appear, overrun stays 2'b10.
- Reset mid-word:
  - Stimulus: 5 lane-1 bits, then pulse rst_n low asynchronously (between edges), then 8 fresh bits giving 8'hFF.
  - Required: all outputs 0 during reset, and the next word is exactly 8'hFF/lane0 with no stale bits.
